// File: rtl/cam_ctrl.sv
// Request-level controller for a CAM_Wrapper: allocates rows on write, tracks occupancy,
// and reduces the CAM match vector to a priority-encoded hit response.
module cam_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int IDX_W     = 3,
  parameter int MATCH_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_word,
  input  logic [WIDTH-1:0]   req_mask,
  input  logic [IDX_W-1:0]   req_index,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_multi,
  output logic [IDX_W-1:0]   resp_index,
  output logic               resp_err,
  output logic               full,
  output logic [IDX_W:0]     count,
  output logic [DEPTH-1:0]   cam_we_row,
  output logic [WIDTH-1:0]   cam_word,
  output logic [WIDTH-1:0]   cam_mask,
  input  logic [DEPTH-1:0]   cam_match
);

  localparam int LAT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SEARCH, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q, mask_q;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               full_q, full_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               hit_q, hit_d, multi_q, multi_d, err_q, err_d;
  logic [IDX_W-1:0]   index_q, index_d;

  logic               accept;
  logic [IDX_W-1:0]   alloc_idx, hit_idx;
  logic [IDX_W:0]     hit_cnt;
  logic [DEPTH-1:0]   eff_match;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_hit   = hit_q;
  assign resp_multi = multi_q;
  assign resp_index = index_q;
  assign resp_err   = err_q;
  assign full       = full_q;
  assign count      = count_q;

  // Rows not tracked as valid may hold stale CAM data, so they never count as hits.
  assign eff_match = cam_match & valid_q;

  always_comb begin
    alloc_idx = '0;
    hit_idx   = '0;
    hit_cnt   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i])  alloc_idx = IDX_W'(i);
      if (eff_match[i]) hit_idx   = IDX_W'(i);
      hit_cnt = hit_cnt + (IDX_W+1)'(eff_match[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    count_d    = count_q;
    lat_d      = lat_q;
    hit_d      = hit_q;
    multi_d    = multi_q;
    err_d      = err_q;
    index_d    = index_q;
    cam_we_row = '0;
    cam_word   = '0;
    cam_mask   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_op == OP_SEARCH) begin
            state_d = S_SEARCH;
            lat_d   = '0;
          end else if (req_op == OP_WRITE) begin
            state_d = S_WRITE;
          end else begin
            hit_d   = 1'b0;
            multi_d = 1'b0;
            err_d   = 1'b0;
            index_d = '0;
            state_d = S_RESP;
            if (req_op == OP_DELETE) begin
              if (valid_q[req_index]) begin
                valid_d[req_index] = 1'b0;
                count_d            = count_q - 1'b1;
              end
            end else begin
              valid_d = '0;
              count_d = '0;
            end
          end
        end
      end
      S_WRITE: begin
        hit_d   = 1'b0;
        multi_d = 1'b0;
        state_d = S_RESP;
        if (full_q) begin
          err_d   = 1'b1;
          index_d = '0;
        end else begin
          if (!rst) cam_we_row = DEPTH'(1) << alloc_idx;
          cam_word           = word_q;
          cam_mask           = mask_q;
          valid_d[alloc_idx] = 1'b1;
          count_d            = count_q + 1'b1;
          err_d              = 1'b0;
          index_d            = alloc_idx;
        end
      end
      S_SEARCH: begin
        cam_word = word_q;
        if (lat_q == LAT_W'(MATCH_LAT - 1)) begin
          hit_d   = |eff_match;
          index_d = hit_idx;
          multi_d = (hit_cnt > (IDX_W+1)'(1));
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_d = (count_d == (IDX_W+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      lat_q   <= '0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      full_q  <= full_d;
      lat_q   <= lat_d;
      hit_q   <= hit_d;
      multi_q <= multi_d;
      err_q   <= err_d;
      index_q <= index_d;
      if (accept) begin
        word_q <= req_word;
        mask_q <= req_mask;
      end
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a small behavioural CAM array answering cam_match.
module tb_cam_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_word, req_mask;
  logic [2:0] req_index;
  logic       resp_valid, resp_hit, resp_multi, resp_err, full;
  logic [2:0] resp_index;
  logic [3:0] count;
  logic [7:0] cam_we_row, cam_word, cam_mask, cam_match;

  int errors = 0;
  int checks = 0;

  logic [7:0] cam_w [8];
  logic [7:0] cam_m [8];

  int         r_lat;
  logic       r_got;
  logic [7:0] r_we, r_we_word, r_we_mask;
  logic       r_ready_in_resp;

  always #5 clk = ~clk;

  cam_ctrl #(.WIDTH(8), .DEPTH(8), .IDX_W(3), .MATCH_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_mask(req_mask), .req_index(req_index),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_multi(resp_multi),
    .resp_index(resp_index), .resp_err(resp_err), .full(full), .count(count),
    .cam_we_row(cam_we_row), .cam_word(cam_word), .cam_mask(cam_mask),
    .cam_match(cam_match)
  );

  // Ternary CAM: a stored mask bit or a search mask bit makes that bit don't-care.
  always @(posedge clk) begin
    for (int r = 0; r < 8; r++) begin
      if (cam_we_row[r]) begin
        cam_w[r] <= cam_word;
        cam_m[r] <= cam_mask;
      end
    end
  end

  always_comb begin
    cam_match = '0;
    for (int r = 0; r < 8; r++)
      cam_match[r] = (((cam_w[r] ^ cam_word) & ~(cam_m[r] | cam_mask)) == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait (bounded) for its response; latency counted in cycles.
  task automatic txn(input logic [1:0] op, input logic [7:0] w, input logic [7:0] m,
                     input logic [2:0] idx);
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_word  = w;
    req_mask  = m;
    req_index = idx;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r_lat = 0; r_got = 1'b0; r_we = '0; r_we_word = '0; r_we_mask = '0;
    r_ready_in_resp = 1'b1;
    for (int c = 1; c <= 20 && !r_got; c++) begin
      @(negedge clk);
      if (cam_we_row != 8'h00) begin
        r_we      = cam_we_row;
        r_we_word = cam_word;
        r_we_mask = cam_mask;
      end
      if (resp_valid) begin
        r_got = 1'b1;
        r_lat = c;
        r_ready_in_resp = req_ready;
      end
    end
    if (!r_got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] w, input logic [7:0] m, input logic [2:0] exp_idx);
    txn(2'b01, w, m, 3'd0);
    chk("wr_lat", r_lat, 2);
    chk("wr_idx", {29'd0, resp_index}, {29'd0, exp_idx});
    chk("wr_we", {24'd0, r_we}, 32'd1 << exp_idx);
    chk("wr_err", {31'd0, resp_err}, 32'd0);
    $display("write word=%02h mask=%02h -> idx=%0d we=%02h lat=%0d count=%0d",
             w, m, resp_index, r_we, r_lat, count);
  endtask

  task automatic do_search(input logic [7:0] key, input logic exp_hit,
                           input logic [2:0] exp_idx, input logic exp_multi);
    txn(2'b00, key, 8'h00, 3'd0);
    chk("srch_lat", r_lat, 2);
    chk("srch_hit", {31'd0, resp_hit}, {31'd0, exp_hit});
    chk("srch_idx", {29'd0, resp_index}, {29'd0, exp_idx});
    chk("srch_multi", {31'd0, resp_multi}, {31'd0, exp_multi});
    $display("search key=%02h -> hit=%0d idx=%0d multi=%0d lat=%0d",
             key, resp_hit, resp_index, resp_multi, r_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_word = '0; req_mask = '0; req_index = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_we_row", {24'd0, cam_we_row}, 32'd0);
    chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_idx", {29'd0, resp_index}, 32'd0);
    $display("reset released: ready=%0d count=%0d", req_ready, count);

    do_write(8'h01, 8'h00, 3'd0);
    chk("ready_low_in_resp", {31'd0, r_ready_in_resp}, 32'd0);
    do_write(8'h02, 8'h00, 3'd1);
    do_write(8'h04, 8'h00, 3'd2);
    chk("count_3", {28'd0, count}, 32'd3);

    do_search(8'h02, 1'b1, 3'd1, 1'b0);
    do_search(8'h33, 1'b0, 3'd0, 1'b0);

    do_write(8'h11, 8'h01, 3'd3);
    chk("wr_mask_to_cam", {24'd0, r_we_mask}, 32'h01);
    chk("wr_word_to_cam", {24'd0, r_we_word}, 32'h11);
    do_search(8'h10, 1'b1, 3'd3, 1'b0);

    do_write(8'h01, 8'h00, 3'd4);
    do_search(8'h01, 1'b1, 3'd0, 1'b1);

    do_write(8'h20, 8'h00, 3'd5);
    do_write(8'h40, 8'h00, 3'd6);
    chk("not_full_at_7", {31'd0, full}, 32'd0);
    do_write(8'h80, 8'h00, 3'd7);
    chk("full_at_8", {31'd0, full}, 32'd1);
    chk("count_8", {28'd0, count}, 32'd8);

    txn(2'b01, 8'h99, 8'h00, 3'd0);
    chk("full_wr_err", {31'd0, resp_err}, 32'd1);
    chk("full_wr_no_we", {24'd0, r_we}, 32'd0);
    chk("full_wr_lat", r_lat, 2);
    chk("full_wr_count", {28'd0, count}, 32'd8);
    $display("write when full -> err=%0d we=%02h lat=%0d", resp_err, r_we, r_lat);

    txn(2'b10, 8'h00, 8'h00, 3'd1);
    chk("del_lat", r_lat, 1);
    chk("del_hit", {31'd0, resp_hit}, 32'd0);
    chk("del_err", {31'd0, resp_err}, 32'd0);
    chk("del_count", {28'd0, count}, 32'd7);
    chk("del_full", {31'd0, full}, 32'd0);
    $display("delete row 1 -> lat=%0d count=%0d full=%0d", r_lat, count, full);
    do_search(8'h02, 1'b0, 3'd0, 1'b0);
    do_write(8'h55, 8'h00, 3'd1);
    chk("count_back_8", {28'd0, count}, 32'd8);

    txn(2'b11, 8'h00, 8'h00, 3'd0);
    chk("clr_lat", r_lat, 1);
    chk("clr_count", {28'd0, count}, 32'd0);
    @(negedge clk);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    $display("clear-all -> lat=%0d count=%0d", r_lat, count);
    do_search(8'h01, 1'b0, 3'd0, 1'b0);
    do_search(8'h55, 1'b0, 3'd0, 1'b0);

    do_write(8'h01, 8'h00, 3'd0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_word = 8'h01; req_mask = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_count", {28'd0, count}, 32'd0);
    chk("rst_mid_we_row", {24'd0, cam_we_row}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_no_resp2", {31'd0, resp_valid}, 32'd0);
    $display("reset during search -> resp_valid=%0d count=%0d ready=%0d",
             resp_valid, count, req_ready);
    do_search(8'h01, 1'b0, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Request-level controller that sequences a `CAM_Wrapper` instance (WIDTH-bit words, DEPTH rows).
- Accepts write, search, delete and clear commands over a valid/ready handshake.
- Allocates free rows and drives the CAM's one-hot row-write port.
- Reduces the CAM's decoded match vector to a priority-encoded hit index.
- Sits between system logic and the CAM; the CAM array itself is never modified.

## Interface
Parameters:
- `WIDTH`, 8, CAM word width.
- `DEPTH`, 8, CAM rows.
- `IDX_W`, 3, row index width; must equal clog2(DEPTH).
- `MATCH_LAT`, 1, cycles from `cam_word` valid to `cam_match` valid (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: controller can accept a command.
- `req_op` in 2: 00 search, 01 write, 10 delete, 11 clear-all.
- `req_word` in WIDTH: write data or search key.
- `req_mask` in WIDTH: don't-care mask stored on write; ignored on search.
- `req_index` in IDX_W: row to delete.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_hit` out 1: search found at least one valid match.
- `resp_multi` out 1: more than one valid row matched.
- `resp_index` out IDX_W: hit row (search) or allocated row (write).
- `resp_err` out 1: write refused because the CAM is full.
- `full` out 1: all rows valid.
- `count` out IDX_W+1: number of valid rows.
- `cam_we_row` out DEPTH: one-hot row write enable to the CAM.
- `cam_word` out WIDTH: CAM search/write word.
- `cam_mask` out WIDTH: CAM dont_care_mask.
- `cam_match` in DEPTH: CAM decoded match address.

## Operation
- Internal `valid_vec[DEPTH]` tracks occupied rows. Effective match = `cam_match & valid_vec`, so stale CAM contents are never reported.
- FSM states: IDLE, WRITE, SEARCH, RESP.
- `req_ready` = (state==IDLE) and not `rst`. A command is accepted on an edge where `req_valid & req_ready`; the command fields are registered at that edge.
- Write:
  - IDLE→WRITE. The allocated row is the lowest index with `valid_vec`=0.
  - If the CAM is full: no CAM access, `resp_err`=1, WRITE→RESP.
  - Otherwise, in WRITE: `cam_we_row`=one-hot(row), `cam_word`=word, `cam_mask`=mask for exactly one cycle. Then `valid_vec[row]` is set, `resp_index`=row, WRITE→RESP.
- Search:
  - IDLE→SEARCH. `cam_word`=key and `cam_mask`=0 are held for MATCH_LAT cycles.
  - On the last SEARCH cycle, effective match is sampled:
    - `resp_hit` = |match.
    - `resp_index` = lowest set bit (0 on miss).
    - `resp_multi` = popcount>1.
  - SEARCH→RESP.
- Delete: `valid_vec[req_index]` is cleared and the FSM goes IDLE→RESP. Deleting a free row is a no-op with a normal response; `resp_hit`=0.
- Clear-all: `valid_vec` = 0 and the FSM goes IDLE→RESP.
- RESP: `resp_valid`=1 for one cycle, then RESP→IDLE. Response fields hold until the next response.
- Unused response flags are 0 for every op.
- `count` and `full` are registered and updated on the same edge as `valid_vec`.
- `cam_we_row` is 0 in every state except an allocating WRITE.

## Timing
- Reset values:
  - `resp_*`, `cam_we_row`, `cam_word`, `cam_mask`, `count` = 0.
  - `full` = 0; `valid_vec` = 0.
  - State = IDLE, so `req_ready`=1 on the first cycle after `rst` deasserts.
- Latency, counted from the acceptance edge to `resp_valid`:
  - Write: CAM write cycle follows the acceptance edge; `resp_valid` 2 cycles after acceptance.
  - Search: MATCH_LAT+1 cycles.
  - Delete and clear: 1 cycle.
  - Full-write error: 2 cycles, with no `cam_we_row` pulse.
- `req_ready` is low from the acceptance edge through the RESP cycle and is high again the cycle after `resp_valid`.
- A search immediately following a write sees the new row (the CAM write completes before SEARCH is entered).
- `rst` mid-operation:
  - Takes effect on the next edge and aborts the command.
  - No `resp_valid`; `cam_we_row` is forced to 0.
  - `valid_vec` is cleared.
- `req_valid` while `req_ready`=0 is ignored; no queuing.

## Test plan
- Writes of 0x01, 0x02, 0x04 (mask 0) after reset → `resp_index` 0, 1, 2; `cam_we_row` 0x01, 0x02, 0x04; `count`=3; each `resp_valid` 2 cycles after acceptance.
- Search 0x02 → `resp_hit`=1, `resp_index`=1, `resp_multi`=0. Search 0x33 → `resp_hit`=0, `resp_index`=0.
- Write 0x11 with mask 0x01 to row 3, then search 0x10 → hit at index 3.
- Write 0x01 again (row 4), search 0x01 → `resp_index`=0, `resp_multi`=1.
- Fill all 8 rows → `full`=1, `count`=8. A 9th write → `resp_err`=1 with no `cam_we_row` pulse. Delete row 1, then search 0x02 → miss. The next write allocates row 1.
- Clear-all → `count`=0; every search misses.
- Assert `rst` during SEARCH → no `resp_valid`; `count`=0; `req_ready`=1 the cycle after `rst` drops.
